// File: rtl/npu_tdp_buffer.sv
// npu_tdp_buffer: single-clock true-dual-port staging buffer with byte enables,
// registered reads, write-collision merge, selectable read-during-write,
// out-of-range detection and a sweep-based clear engine.
module npu_tdp_buffer #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned DEPTH         = 20480,
  parameter int unsigned ADDR_W        = 16,
  parameter bit          RD_MODE       = 1'b0,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_req,
  output logic                init_busy,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   din_a,
  output logic [DATA_W-1:0]   dout_a,
  output logic                vld_a,
  output logic                err_a,
  input  logic                en_b,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   din_b,
  output logic [DATA_W-1:0]   dout_b,
  output logic                vld_b,
  output logic                err_b,
  output logic                collision
);

  localparam int unsigned      NB      = DATA_W / 8;
  localparam int unsigned      IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  logic [DATA_W-1:0]   ram_a_q, ram_b_q;
  logic                oor_a_q, oor_b_q;
  logic                byp_a_q, byp_b_q;
  logic [NB-1:0]       byp_be_a_q, byp_be_b_q;
  logic [DATA_W-1:0]   byp_dat_a_q, byp_dat_b_q;
  logic                vld_a_q, vld_b_q, err_a_q, err_b_q, coll_q;

  logic                run, clr, inr_a, inr_b, rd_a, rd_b, wok_a, wok_b, coll;
  logic [IDX_W-1:0]    idx_a, idx_b;
  logic                mwe_a, mwe_b;
  logic [IDX_W-1:0]    maddr_a, maddr_b;
  logic [NB-1:0]       mbe_a, mbe_b;
  logic [DATA_W-1:0]   mdat_a, mdat_b;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [NB-1:0]     be,
                                                    input logic [DATA_W-1:0] new_w);
    merge_bytes = old_w;
    for (int unsigned i = 0; i < NB; i++) begin
      if (be[i]) merge_bytes[i*8 +: 8] = new_w[i*8 +: 8];
    end
  endfunction

  assign idx_a = addr_a[IDX_W-1:0];
  assign idx_b = addr_b[IDX_W-1:0];
  assign inr_a = {1'b0, addr_a} < DEPTH_X;
  assign inr_b = {1'b0, addr_b} < DEPTH_X;
  assign run   = rst_n && (state_q == IDLE);
  assign clr   = rst_n && (state_q == CLEAR);
  assign rd_a  = run && en_a && !we_a;
  assign rd_b  = run && en_b && !we_b;
  assign wok_a = run && en_a && we_a && inr_a;
  assign wok_b = run && en_b && we_b && inr_b;
  assign coll  = wok_a && wok_b && (idx_a == idx_b);

  // Build the two physical write channels; a same-address pair is folded into
  // channel A (A bytes win, B fills the rest) so the array never sees two writes
  // to one word, and the clear sweep borrows channel A.
  always_comb begin
    mwe_a   = wok_a;
    maddr_a = idx_a;
    mbe_a   = be_a;
    mdat_a  = din_a;
    if (coll) begin
      mbe_a  = be_a | be_b;
      mdat_a = merge_bytes(din_b, be_a, din_a);
    end
    if (clr) begin
      mwe_a   = 1'b1;
      maddr_a = ptr_q;
      mbe_a   = '1;
      mdat_a  = '0;
    end
    mwe_b   = wok_b && !coll;
    maddr_b = idx_b;
    mbe_b   = be_b;
    mdat_b  = din_b;
  end

  // Plain byte-enabled dual-port array with synchronous read-before-write ports.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (mwe_a && mbe_a[i]) mem[maddr_a][i*8 +: 8] <= mdat_a[i*8 +: 8];
      if (mwe_b && mbe_b[i]) mem[maddr_b][i*8 +: 8] <= mdat_b[i*8 +: 8];
    end
    if (rd_a && inr_a) ram_a_q <= mem[idx_a];
    if (rd_b && inr_b) ram_b_q <= mem[idx_b];
  end

  // Clear-engine FSM plus registered strobes and read-side bypass/range tags.
  // The range tag resets to 1 so dout reads as zero without resetting the RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT_ON_RESET ? CLEAR : IDLE;
      ptr_q       <= '0;
      vld_a_q     <= 1'b0;
      vld_b_q     <= 1'b0;
      err_a_q     <= 1'b0;
      err_b_q     <= 1'b0;
      coll_q      <= 1'b0;
      oor_a_q     <= 1'b1;
      oor_b_q     <= 1'b1;
      byp_a_q     <= 1'b0;
      byp_b_q     <= 1'b0;
      byp_be_a_q  <= '0;
      byp_be_b_q  <= '0;
      byp_dat_a_q <= '0;
      byp_dat_b_q <= '0;
    end else begin
      vld_a_q <= rd_a;
      vld_b_q <= rd_b;
      err_a_q <= run && en_a && !inr_a;
      err_b_q <= run && en_b && !inr_b;
      coll_q  <= coll;
      if (rd_a) begin
        oor_a_q     <= !inr_a;
        byp_a_q     <= RD_MODE && inr_a && mwe_b && (maddr_b == idx_a);
        byp_be_a_q  <= mbe_b;
        byp_dat_a_q <= mdat_b;
      end
      if (rd_b) begin
        oor_b_q     <= !inr_b;
        byp_b_q     <= RD_MODE && inr_b && mwe_a && (maddr_a == idx_b);
        byp_be_b_q  <= mbe_a;
        byp_dat_b_q <= mdat_a;
      end
      case (state_q)
        IDLE: begin
          if (init_req) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
          end
        end
        CLEAR: begin
          if (ptr_q == LAST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout_a    = oor_a_q ? '0 : merge_bytes(ram_a_q, byp_a_q ? byp_be_a_q : '0, byp_dat_a_q);
  assign dout_b    = oor_b_q ? '0 : merge_bytes(ram_b_q, byp_b_q ? byp_be_b_q : '0, byp_dat_b_q);
  assign vld_a     = vld_a_q;
  assign vld_b     = vld_b_q;
  assign err_a     = err_a_q;
  assign err_b     = err_b_q;
  assign collision = coll_q;
  assign init_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_npu_tdp_buffer.sv
// Bench for npu_tdp_buffer: two instances (old-data and new-data read-during-write)
// share stimulus and are checked every cycle against a word-level memory model.
module tb_npu_tdp_buffer;

  localparam int DEP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, init_req, en_a, we_a, en_b, we_b;
  logic [1:0]  be_a, be_b;
  logic [4:0]  addr_a, addr_b;
  logic [15:0] din_a, din_b;
  logic [15:0] dout_a [2];
  logic [15:0] dout_b [2];
  logic        vld_a [2], vld_b [2], err_a [2], err_b [2], coll [2], busy [2];

  npu_tdp_buffer #(.DATA_W(16), .DEPTH(16), .ADDR_W(5), .RD_MODE(1'b0), .INIT_ON_RESET(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_busy(busy[0]),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a[0]), .vld_a(vld_a[0]), .err_a(err_a[0]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b[0]), .vld_b(vld_b[0]), .err_b(err_b[0]), .collision(coll[0]));

  npu_tdp_buffer #(.DATA_W(16), .DEPTH(16), .ADDR_W(5), .RD_MODE(1'b1), .INIT_ON_RESET(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_busy(busy[1]),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a[1]), .vld_a(vld_a[1]), .err_a(err_a[1]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b[1]), .vld_b(vld_b[1]), .err_b(err_b[1]), .collision(coll[1]));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;
  bit rst_want = 1'b0;

  // Model: a word array, a "sweep in progress" flag with the next address to zero,
  // and the outputs each instance must show after the coming edge.
  logic [15:0] m_mem [DEP];
  bit          m_busy;
  int          m_ptr;
  logic [15:0] e_dout_a [2];
  logic [15:0] e_dout_b [2];
  bit          e_vld_a, e_vld_b, e_err_a, e_err_b, e_coll, e_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] apply_be(input logic [15:0] old_w, input logic [1:0] be,
                                           input logic [15:0] d);
    logic [15:0] r;
    r = old_w;
    if (be[0]) r[7:0]  = d[7:0];
    if (be[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  task automatic model_step();
    logic [15:0] pre [DEP];
    bit wa, wb;
    if (!rst_n) begin
      e_vld_a = 0; e_vld_b = 0; e_err_a = 0; e_err_b = 0; e_coll = 0;
      for (int k = 0; k < 2; k++) begin e_dout_a[k] = '0; e_dout_b[k] = '0; end
      m_busy = 1; m_ptr = 0;
    end else if (m_busy) begin
      m_mem[m_ptr] = '0;
      m_ptr++;
      if (m_ptr == DEP) begin m_busy = 0; m_ptr = 0; end
      e_vld_a = 0; e_vld_b = 0; e_err_a = 0; e_err_b = 0; e_coll = 0;
    end else begin
      pre = m_mem;
      wa = en_a && we_a && (int'(addr_a) < DEP);
      wb = en_b && we_b && (int'(addr_b) < DEP);
      // B first, then A on top: A owns every byte it enables.
      if (wb) m_mem[addr_b[3:0]] = apply_be(m_mem[addr_b[3:0]], be_b, din_b);
      if (wa) m_mem[addr_a[3:0]] = apply_be(m_mem[addr_a[3:0]], be_a, din_a);
      e_coll  = wa && wb && (addr_a == addr_b);
      e_err_a = en_a && (int'(addr_a) >= DEP);
      e_err_b = en_b && (int'(addr_b) >= DEP);
      e_vld_a = en_a && !we_a;
      e_vld_b = en_b && !we_b;
      if (e_vld_a) begin
        e_dout_a[0] = (int'(addr_a) < DEP) ? pre[addr_a[3:0]]   : 16'h0;
        e_dout_a[1] = (int'(addr_a) < DEP) ? m_mem[addr_a[3:0]] : 16'h0;
      end
      if (e_vld_b) begin
        e_dout_b[0] = (int'(addr_b) < DEP) ? pre[addr_b[3:0]]   : 16'h0;
        e_dout_b[1] = (int'(addr_b) < DEP) ? m_mem[addr_b[3:0]] : 16'h0;
      end
      if (init_req) begin m_busy = 1; m_ptr = 0; end
    end
    e_busy = m_busy;
  endtask

  // Every cycle: both instances against the model.
  always @(posedge clk) begin
    if (chk_on) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dout_a%0d", k), 32'(dout_a[k]), 32'(e_dout_a[k]));
        chk($sformatf("dout_b%0d", k), 32'(dout_b[k]), 32'(e_dout_b[k]));
        chk($sformatf("vld_a%0d", k),  32'(vld_a[k]),  32'(e_vld_a));
        chk($sformatf("vld_b%0d", k),  32'(vld_b[k]),  32'(e_vld_b));
        chk($sformatf("err_a%0d", k),  32'(err_a[k]),  32'(e_err_a));
        chk($sformatf("err_b%0d", k),  32'(err_b[k]),  32'(e_err_b));
        chk($sformatf("coll%0d", k),   32'(coll[k]),   32'(e_coll));
        chk($sformatf("busy%0d", k),   32'(busy[k]),   32'(e_busy));
      end
    end
  end

  task automatic cyc(input bit ea, input bit wa, input logic [1:0] ba, input logic [4:0] aa,
                     input logic [15:0] da, input bit eb, input bit wb, input logic [1:0] bb,
                     input logic [4:0] ab, input logic [15:0] db, input bit ir);
    @(negedge clk);
    rst_n = rst_want;
    en_a = ea; we_a = wa; be_a = ba; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; be_b = bb; addr_b = ab; din_b = db;
    init_req = ir;
    model_step();
    chk_on = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic nop(input bit ir);
    cyc(0, 0, 2'b00, 5'd0, 16'h0, 0, 0, 2'b00, 5'd0, 16'h0, ir);
  endtask

  task automatic rda(input logic [4:0] a);
    cyc(1, 0, 2'b00, a, 16'h0, 0, 0, 2'b00, 5'd0, 16'h0, 0);
  endtask

  task automatic wra(input logic [4:0] a, input logic [1:0] be, input logic [15:0] d);
    cyc(1, 1, be, a, d, 0, 0, 2'b00, 5'd0, 16'h0, 0);
  endtask

  // Counts cycles with init_busy high, issuing optional writes/init pulses meanwhile.
  task automatic count_sweep(input bit with_req, input bit with_wr, output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (!busy[0]) break;
      cnt++;
      cyc(with_wr, with_wr, 2'b11, 5'd0, 16'hDEAD, 0, 0, 2'b00, 5'd0, 16'h0, with_req);
    end
  endtask

  initial begin
    int cnt;
    rst_n = 0; init_req = 0; en_a = 0; we_a = 0; en_b = 0; we_b = 0;
    be_a = '0; be_b = '0; addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;

    // Reset, then the automatic sweep with writes to addr 0 that must be ignored.
    rst_want = 0;
    nop(0); nop(0);
    settle();
    chk("rst_busy", 32'(busy[0]), 32'd1);
    chk("rst_dout", 32'(dout_a[0]), 32'd0);
    rst_want = 1;
    count_sweep(0, 1, cnt);
    chk("sweep_len", 32'(cnt), 32'd16);
    for (int a = 0; a < DEP; a++) begin
      rda(5'(a));
      settle();
      chk("clr_rd", 32'(dout_a[0]), 32'h0);
      chk("clr_vld", 32'(vld_a[0]), 32'd1);
    end

    // Byte enables across ports.
    wra(5'd3, 2'b11, 16'hBEEF);
    cyc(0, 0, 2'b00, 5'd0, 16'h0, 1, 1, 2'b01, 5'd3, 16'h1234, 0);
    rda(5'd3);
    settle();
    chk("be_rd0", 32'(dout_a[0]), 32'hBE34);
    chk("be_rd1", 32'(dout_a[1]), 32'hBE34);

    // Write/write collision.
    cyc(1, 1, 2'b10, 5'd5, 16'hAAAA, 1, 1, 2'b11, 5'd5, 16'h5555, 0);
    settle();
    chk("coll_flag", 32'(coll[0]), 32'd1);
    rda(5'd5);
    settle();
    chk("coll_rd", 32'(dout_a[0]), 32'hAA55);

    // Read-during-write on the other port.
    wra(5'd7, 2'b11, 16'h1111);
    cyc(1, 1, 2'b11, 5'd7, 16'h2222, 1, 0, 2'b00, 5'd7, 16'h0, 0);
    settle();
    chk("rdw_old", 32'(dout_b[0]), 32'h1111);
    chk("rdw_new", 32'(dout_b[1]), 32'h2222);
    cyc(0, 0, 2'b00, 5'd0, 16'h0, 1, 0, 2'b00, 5'd7, 16'h0, 0);
    settle();
    chk("rdw_after0", 32'(dout_b[0]), 32'h2222);
    chk("rdw_after1", 32'(dout_b[1]), 32'h2222);

    // Out of range.
    rda(5'd16);
    settle();
    chk("oor_dout", 32'(dout_a[0]), 32'h0);
    chk("oor_vld", 32'(vld_a[0]), 32'd1);
    chk("oor_err", 32'(err_a[0]), 32'd1);
    wra(5'd20, 2'b11, 16'hFFFF);
    settle();
    chk("oor_werr", 32'(err_a[0]), 32'd1);
    rda(5'd4);
    settle();
    chk("oor_a4", 32'(dout_a[0]), 32'h0);
    chk("oor_once", 32'(err_a[0]), 32'd0);

    // Fill, start a clear, reset part-way through, re-sweep with ignored init pulses.
    for (int a = 0; a < DEP; a++) wra(5'(a), 2'b11, 16'hFFFF);
    nop(1);
    for (int i = 0; i < 9; i++) nop(0);
    rst_want = 0;
    nop(0); nop(0);
    rst_want = 1;
    count_sweep(1, 0, cnt);
    chk("resweep_len", 32'(cnt), 32'd16);
    for (int a = 0; a < DEP; a++) begin
      rda(5'(a));
      settle();
      chk("reclr_rd", 32'(dout_a[1]), 32'h0);
    end

    // Randomised traffic, occasionally colliding and occasionally re-clearing.
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] aa, ab;
      aa = 5'($urandom_range(0, 19));
      ab = ($urandom_range(0, 3) == 0) ? aa : 5'($urandom_range(0, 19));
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), aa,
          16'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ab,
          16'($urandom),
          $urandom_range(0, 299) == 0);
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_tdp_buffer.md
# npu_tdp_buffer

Parametrised single-clock true-dual-port buffer for NPU activation and weight staging. It succeeds the fixed 16-bit/20480-word dual-port memory with configurable width and depth, byte enables, and registered reads with valid strobes. It also adds deterministic write-collision resolution, a selectable read-during-write mode, out-of-range detection and a hardware clear engine. It sits between the DMA/load unit (port A) and the PE-array feeder (port B).

## Interface
- DATA_W, 16, word width in bits; multiple of 8
- DEPTH, 20480, number of words
- ADDR_W, 16, address width; requires 2**ADDR_W >= DEPTH
- RD_MODE, 0, cross-port read-during-write: 0 returns old data, 1 returns new (merged) data
- INIT_ON_RESET, 1, 1 = start a clear sweep automatically on reset release
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- init_req  in  1  one-cycle pulse in IDLE to start a clear sweep
- init_busy  out  1  high while the clear sweep runs
- en_a / en_b  in  1  port request valid
- we_a / we_b  in  1  1 = write, 0 = read (qualified by en)
- be_a / be_b  in  DATA_W/8  byte enables for writes
- addr_a / addr_b  in  ADDR_W  word address
- din_a / din_b  in  DATA_W  write data
- dout_a / dout_b  out  DATA_W  registered read data
- vld_a / vld_b  out  1  dout valid, one-cycle pulse per read
- err_a / err_b  out  1  pulse: request address >= DEPTH
- collision  out  1  pulse: both ports wrote the same address

## Operation
- FSM states are IDLE and CLEAR.
- Reset (rst_n low at an edge):
  - Forces the state to CLEAR if INIT_ON_RESET, else IDLE, and sets the clear pointer to 0.
  - Outputs reset to 0: dout, vld, err, collision.
  - init_busy is combinational (state==CLEAR), so it is 1 during reset when INIT_ON_RESET=1.
  - Memory contents are not reset by rst_n itself.
- CLEAR:
  - Writes 0 to address ptr each cycle; ptr increments.
  - After writing DEPTH-1, goes to IDLE and ptr returns to 0.
  - All port requests are ignored: no writes, vld/err/collision stay 0.
  - init_req is ignored.
- IDLE:
  - init_req=1 enters CLEAR with ptr=0. Port requests in that same cycle are still served.
- Write (en & we, addr < DEPTH): byte i is updated only where be[i]=1. be=0 is a legal no-op.
- Read (en & !we, addr < DEPTH): dout and vld update on the next edge.
- When no read is issued, dout holds its last value and vld=0.
- Out of range (addr >= DEPTH):
  - A write is dropped.
  - A read returns dout=0 with vld=1.
  - err pulses on the next edge for both reads and writes.
- Write/write to the same address:
  - Each byte enabled by be_a takes din_a.
  - Bytes enabled only by be_b take din_b.
  - collision=1 on the next edge, even if no byte enables overlap.
- Cross-port read/write to the same address:
  - RD_MODE=0: the reader gets the pre-write word.
  - RD_MODE=1: the reader gets the post-write merged word.
- Simultaneous reads of the same address from both ports are always legal and return identical data.
- Memory array is inferable as block RAM. The collision and merge logic sits outside the array and must not break inference.

## Timing
- Read latency is 1 cycle: a request at edge N gives dout/vld valid after edge N+1.
- Throughput: one request per port per cycle, with no stalls outside CLEAR.
- Writes are visible to same-port or other-port reads issued on the following cycle.
- Clear sweep:
  - The first edge with rst_n=1 (or the edge after init_req) writes address 0.
  - The edge k later writes address k.
  - init_busy falls after the edge writing DEPTH-1; the sweep lasts DEPTH cycles.
  - Requests are accepted from the next edge.
- rst_n low mid-sweep: the sweep restarts from address 0 after release if INIT_ON_RESET, else the FSM stays in IDLE with partial contents.
- err and collision are 1-cycle pulses aligned with vld timing (edge N+1).

## Test plan
- DEPTH=16, INIT_ON_RESET=1:
  - Stimulus: release rst_n and count cycles.
  - Required: init_busy high for exactly 16 cycles; every address then reads 0x0000 with vld after 1 cycle.
  - Stimulus: en_a/we_a requests during the sweep.
  - Required: the requests have no effect.
- Byte enables:
  - Stimulus: write 0xBEEF to addr 3 with be_a=2'b11, then write din_b=0x1234 to addr 3 with be_b=2'b01.
  - Required: a read returns 0xBE34 one cycle later, vld_a=1.
- Write/write collision:
  - Stimulus: both ports write addr 5 in the same cycle; A=0xAAAA be=2'b10, B=0x5555 be=2'b11.
  - Required: collision=1 next cycle; readback 0xAA55.
- Read-during-write:
  - Stimulus: addr 7 holds 0x1111; A writes 0x2222 while B reads addr 7.
  - Required: dout_b=0x1111 for RD_MODE=0 and 0x2222 for RD_MODE=1; a subsequent read returns 0x2222 in both modes.
- Out of range (DEPTH=16):
  - Stimulus: read addr 16.
  - Required: dout=0, vld=1, err=1.
  - Stimulus: write addr 20, then read addr 4.
  - Required: addr 4 is unchanged and err pulses once.
- Reset mid-sweep:
  - Stimulus: assert rst_n low at ptr=9 for 2 cycles, then release.
  - Required: init_busy stays high for a full 16 cycles; init_req during the sweep is ignored.
  - Stimulus: init_req in IDLE after writing 0xFFFF.
  - Required: the memory re-clears to 0.
